// File: rtl/mpmc10_req_fifo.sv
// Parametrised request FIFO (standard or first-word-fall-through read) with synchronous flush.
// Optional sticky overflow/underflow outputs when MPMC10_FIFO_ERRFLAGS_EN is defined.
module mpmc10_req_fifo #(
  parameter int unsigned WID          = 256,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned AFULL_THRESH = 27,
  parameter int unsigned FWFT         = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WID-1:0]           din,
  input  logic                     rd_en,
  output logic [WID-1:0]           dout,
  output logic                     v,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
`ifdef MPMC10_FIFO_ERRFLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WID-1:0] mem_q [DEPTH];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic           empty_q, empty_d;
  logic           full_q, full_d;
  logic           afull_q, afull_d;
  logic           wr_acc, rd_acc;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic [WID-1:0] rd_word;

  // In FWFT mode v == ~empty, so one accept term serves both read modes.
  always_comb begin
    wr_addr  = wr_ptr_q[AW-1:0];
    rd_addr  = rd_ptr_q[AW-1:0];
    rd_word  = mem_q[rd_addr];
    wr_acc   = wr_en & ~full_q & ~clr;
    rd_acc   = rd_en & ~empty_q & ~clr;
    wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    cnt_d   = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    afull_d = (cnt_d >= PW'(AFULL_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  // Storage is deliberately unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_addr] <= din;
    end
  end

  always_comb begin
    cnt         = cnt_q;
    empty       = empty_q;
    full        = full_q;
    almost_full = afull_q;
  end

  if (FWFT == 0) begin : g_std
    logic [WID-1:0] dout_q, dout_d;
    logic           v_q, v_d;

    always_comb begin
      dout_d = dout_q;
      v_d    = rd_acc;
      if (clr) begin
        dout_d = '0;
      end else if (rd_acc) begin
        dout_d = rd_word;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        v_q    <= 1'b0;
      end else begin
        dout_q <= dout_d;
        v_q    <= v_d;
      end
    end

    always_comb begin
      dout = dout_q;
      v    = v_q;
    end
  end else begin : g_fwft
    // Masked while empty so dout reads all-zero after reset/flush.
    always_comb begin
      v    = ~empty_q;
      dout = empty_q ? '0 : rd_word;
    end
  end

`ifdef MPMC10_FIFO_ERRFLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en & full_q);
    unf_d = unf_q | (rd_en & empty_q);
    if (clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_comb begin
    overflow  = ovf_q;
    underflow = unf_q;
  end
`endif

endmodule

// File: tb/tb_mpmc10_req_fifo.sv
// Scoreboard bench: a standard-read instance checked through a data queue, plus a FWFT instance
// checked directly.
module tb_mpmc10_req_fifo;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         s_clr, s_wr, s_rd;
  logic [W-1:0] s_din, s_dout;
  logic         s_v, s_full, s_af, s_empty;
  logic [5:0]   s_cnt;
  logic         f_clr, f_wr, f_rd;
  logic [W-1:0] f_din, f_dout;
  logic         f_v, f_full, f_af, f_empty;
  logic [5:0]   f_cnt;
`ifdef MPMC10_FIFO_ERRFLAGS_EN
  logic s_ovf, s_unf, f_ovf, f_unf;
`endif

  mpmc10_req_fifo #(.WID(W), .DEPTH(32), .AFULL_THRESH(27), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .wr_en(s_wr), .din(s_din), .rd_en(s_rd),
    .dout(s_dout), .v(s_v), .full(s_full), .almost_full(s_af), .empty(s_empty), .cnt(s_cnt)
`ifdef MPMC10_FIFO_ERRFLAGS_EN
    , .overflow(s_ovf), .underflow(s_unf)
`endif
  );

  mpmc10_req_fifo #(.WID(W), .DEPTH(32), .AFULL_THRESH(27), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
    .dout(f_dout), .v(f_v), .full(f_full), .almost_full(f_af), .empty(f_empty), .cnt(f_cnt)
`ifdef MPMC10_FIFO_ERRFLAGS_EN
    , .overflow(f_ovf), .underflow(f_unf)
`endif
  );

  int vecs = 0;
  int errs = 0;
  logic [W-1:0] mdl[$];
  logic [W-1:0] expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One std-instance cycle; the model decides acceptance from its pre-edge occupancy.
  task automatic step(input bit wr, input logic [W-1:0] d, input bit rd);
    bit emp_m, full_m;
    emp_m = (mdl.size() == 0);
    full_m = (mdl.size() == 32);
    s_wr = wr;
    s_din = d;
    s_rd = rd;
    if (rd && !emp_m) expq.push_back(mdl.pop_front());
    if (wr && !full_m) mdl.push_back(d);
    tick;
    s_wr = 1'b0;
    s_rd = 1'b0;
  endtask

  task automatic st(input string tag);
    chk({tag, "_cnt"}, 32'(s_cnt), mdl.size());
    chk({tag, "_empty"}, 32'(s_empty), 32'(mdl.size() == 0));
    chk({tag, "_full"}, 32'(s_full), 32'(mdl.size() == 32));
    chk({tag, "_afull"}, 32'(s_af), 32'(mdl.size() >= 27));
  endtask

  // Monitor: every cycle the std instance presents v, its data must match the scoreboard head.
  always @(negedge clk) begin
    if (s_v === 1'b1) begin
      if (expq.size() == 0) chk("std_unexpected_v", 32'(s_v), 32'd0);
      else chk("std_dout", 32'(s_dout), 32'(expq.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0;
    s_clr = 0; s_wr = 0; s_rd = 0; s_din = '0;
    f_clr = 0; f_wr = 0; f_rd = 0; f_din = '0;
    #12;
    st("rst");
    chk("rst_v", 32'(s_v), 0);
    chk("rst_dout", 32'(s_dout), 0);
    #3 rst_n = 1'b1;
    tick;

    // Flush with a concurrent write: nothing is stored.
    step(1, 16'h0001, 0);
    step(1, 16'h0002, 0);
    step(1, 16'h0003, 0);
    st("w3");
    s_clr = 1; s_wr = 1; s_din = 16'h0077;
    tick;
    s_clr = 0; s_wr = 0;
    mdl.delete();
    st("clr");
    chk("clr_v", 32'(s_v), 0);
    chk("clr_dout", 32'(s_dout), 0);
`ifdef MPMC10_FIFO_ERRFLAGS_EN
    chk("clr_unf", 32'(s_unf), 0);
`endif
    step(0, '0, 1);
    chk("empty_rd_v", 32'(s_v), 0);
    st("clr_rd");
`ifdef MPMC10_FIFO_ERRFLAGS_EN
    chk("unf_set", 32'(s_unf), 1);
    s_clr = 1;
    tick;
    s_clr = 0;
    chk("unf_cleared", 32'(s_unf), 0);
`endif

    // Fill to full, watching almost_full/full each cycle.
    for (int i = 0; i < 32; i++) begin
      step(1, W'(i), 0);
      st("fill");
    end
    chk("fill_cnt32", 32'(s_cnt), 32);
    step(1, 16'hDEAD, 0);
    st("ovf");
`ifdef MPMC10_FIFO_ERRFLAGS_EN
    chk("ovf_set", 32'(s_ovf), 1);
`endif

    // Read+write at full: read wins, write rejected.
    step(1, 16'hBEEF, 1);
    st("full_rw");
    chk("full_rw_cnt31", 32'(s_cnt), 31);
    while (mdl.size() > 0) step(0, '0, 1);
    tick;
    st("drained");
    chk("drained_exp", expq.size(), 0);

    // Ordering and one-cycle latency.
    step(1, 16'h00A1, 0);
    step(1, 16'h00A2, 0);
    step(1, 16'h00A3, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1);
      chk("ord_v", 32'(s_v), 1);
    end
    step(0, '0, 1);
    chk("ord_4th_v", 32'(s_v), 0);
    tick;
    chk("ord_exp", expq.size(), 0);

    // Sustained concurrent traffic at depth 5, crossing pointer wrap.
    for (int k = 0; k < 5; k++) step(1, W'(16'h0100 + k), 0);
    for (int i = 0; i < 100; i++) begin
      step(1, W'(16'h0200 + i), 1);
      chk("wrap_cnt", 32'(s_cnt), 5);
    end
    while (mdl.size() > 0) step(0, '0, 1);
    tick;
    st("wrap_end");
    chk("wrap_exp", expq.size(), 0);

    // Asynchronous reset between edges while a read result is on dout.
    step(1, 16'h0300, 0);
    step(1, 16'h0301, 0);
    s_rd = 1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    s_rd = 0;
    #1;
    chk("arst_v", 32'(s_v), 0);
    chk("arst_cnt", 32'(s_cnt), 0);
    chk("arst_empty", 32'(s_empty), 1);
    chk("arst_dout", 32'(s_dout), 0);
    mdl.delete();
    expq.delete();
    #10 rst_n = 1'b1;
    tick;
    st("arst_rel");

    // FWFT instance.
    chk("fw_rst_v", 32'(f_v), 0);
    chk("fw_rst_dout", 32'(f_dout), 0);
    f_wr = 1; f_din = 16'h0055;
    tick;
    f_wr = 0;
    chk("fw_v", 32'(f_v), 1);
    chk("fw_dout", 32'(f_dout), 32'h55);
    chk("fw_cnt", 32'(f_cnt), 1);
    f_rd = 1;
    tick;
    f_rd = 0;
    chk("fw_pop_empty", 32'(f_empty), 1);
    chk("fw_pop_v", 32'(f_v), 0);
    f_rd = 1;
    tick;
    f_rd = 0;
    chk("fw_rd_empty_cnt", 32'(f_cnt), 0);
    chk("fw_rd_empty_e", 32'(f_empty), 1);
`ifdef MPMC10_FIFO_ERRFLAGS_EN
    chk("fw_unf", 32'(f_unf), 1);
`endif
    f_wr = 1; f_din = 16'h0061;
    tick;
    f_din = 16'h0062;
    tick;
    f_wr = 0;
    chk("fw_head1", 32'(f_dout), 32'h61);
    f_rd = 1;
    tick;
    chk("fw_head2", 32'(f_dout), 32'h62);
    chk("fw_cnt2", 32'(f_cnt), 1);
    tick;
    f_rd = 0;
    chk("fw_final_empty", 32'(f_empty), 1);

    tick;
    chk("final_exp", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mpmc10_req_fifo.md
Name: mpmc10_req_fifo

Overview:
- Parametrised synchronous FIFO for memory-controller command requests (wb_cmd_request-style payloads) between a port front-end and the arbiter.
- Generalises the fixed 32-deep, 256-bit vendor-FIFO wrapper: width and depth are parameters, the almost-full threshold is programmable, and there is a first-word-fall-through mode and a synchronous flush.
- Pure RTL with no vendor primitives. Storage is a register or distributed-RAM array, so it can be used in both 128- and 256-bit port builds.

Parameters:
- WID, 256, payload width in bits. Set to $bits of the request struct at instantiation.
- DEPTH, 32, number of entries; power of two, 4..256.
- AFULL_THRESH, 27, almost_full asserts when the count is >= this value; legal range 1..DEPTH.
- FWFT, 0, read mode. 0 = standard (latency-1 read); 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush; empties the FIFO
- wr_en  in  1  write request
- din  in  WID  write data
- rd_en  in  1  read request (std) / pop (FWFT)
- dout  out  WID  read data
- v  out  1  dout holds valid data
- full  out  1  no write will be accepted
- almost_full  out  1  count >= AFULL_THRESH
- empty  out  1  no stored words
- cnt  out  $clog2(DEPTH)+1  words stored, range 0..DEPTH inclusive

Behaviour:
- Reset (rst_n=0, asynchronous) and clr=1 (synchronous) give the same state:
  - pointers 0, cnt 0, empty 1, full 0, almost_full 0, v 0, dout all-zero.
  - clr overrides wr_en and rd_en in the same cycle; nothing is written or read.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; the address is the low $clog2(DEPTH) bits.
  - empty = (wr_ptr == rd_ptr). full = address bits equal and MSBs differ.
  - cnt = wr_ptr - rd_ptr, registered. empty, full, almost_full and cnt all update on the edge after the accepted operation.
- Write:
  - Accepted iff wr_en & ~full; mem[wr_addr] <= din and wr_ptr increments.
  - Writes while full are dropped; contents unchanged, no error.
- Standard read (FWFT=0):
  - Accepted iff rd_en & ~empty. dout <= mem[rd_addr] on that edge, so data appears one cycle after the request.
  - v=1 for exactly that one cycle. dout holds its last value when no read is accepted.
  - A read while empty is ignored and gives v=0 the next cycle.
- FWFT read (FWFT=1):
  - dout = mem[rd_addr] (combinational from storage) and v = ~empty.
  - rd_en & v pops the word; rd_en while v=0 is ignored.
  - A word written at edge N is visible on dout/v after edge N, with no extra latency.
- Simultaneous read and write:
  - When neither full nor empty, both are accepted and cnt is unchanged.
  - When full: the read is accepted and the write is rejected (full is evaluated before the read).
  - When empty: the write is accepted and the read is rejected (std mode: v=0 next cycle).
- Reset mid-operation: any pending std-mode read data is discarded and v drops immediately.

Optional Feature:
- Macro: MPMC10_FIFO_ERRFLAGS_EN.
- Defined: adds outputs overflow and underflow (1 bit each).
  - Sticky flags, set on the edge after a rejected write (wr_en & full) or a rejected read (std: rd_en & empty; FWFT: rd_en & ~v).
  - Cleared only by rst_n or clr; reset value 0.
- Not defined: ports absent; rejected operations are silent.

Test Plan:
- Reset/flush: hold rst_n=0, then release → empty=1, full=0, cnt=0, v=0, dout=0. After 3 writes, pulse clr=1 with wr_en=1 → cnt=0, empty=1, and the write is not stored.
- Fill/overflow (DEPTH=32, AFULL_THRESH=27):
  - Write 0..31 → almost_full rises the cycle after the 27th write; full=1 and cnt=32 after the 32nd.
  - A 33rd write of 0xDEAD → dropped, cnt stays 32, overflow=1 if MPMC10_FIFO_ERRFLAGS_EN.
- Std-mode ordering and latency: write 0xA1,0xA2,0xA3, then rd_en for 3 cycles → dout=0xA1,0xA2,0xA3 each one cycle after its request, with v high for 3 cycles. A 4th rd_en → v=0.
- FWFT mode: write 0x55 at edge N → v=1 and dout=0x55 after edge N. rd_en=1 → empty=1 and v=0 after the next edge.
- Wrap-around and simultaneous ops:
  - Run 100 cycles of concurrent wr_en/rd_en at cnt=5 → cnt stays 5 and data is in order across pointer wrap.
  - At full, rd_en and wr_en together → cnt goes to 31 and the write is rejected.
- Async reset mid-stream: assert rst_n=0 between clock edges during a std read → v and cnt are 0 immediately, without waiting for a clock edge.
